fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//   Instruction fetch/phase sequencer for the 4-bit CPU. Sits between program ROM and the
//   decode ROM: holds PC, issues ROM reads, latches opcode/operand byte and address byte,
//   holds C/Z flags, produces 7-bit decode address {instr,C,Z,phase}. Execute-phase PC load
//   and flag write are driven back from decode outputs.
// PARAMETERS
//   ADDR_W  12  PC / ROM / data-memory address width
//   DATA_W   8  ROM word width (opcode nibble + operand nibble)
//   NIB_W    4  instr/oprnd nibble width; DATA_W == 2*NIB_W
// PORTS
//   clk         in   1       system clock, rising edge
//   reset       in   1       asynchronous, active-low reset
//   enable      in   1       1 = run; 0 = freeze all state, rom_req forced 0
//   rom_addr    out  ADDR_W  ROM read address (= pc)
//   rom_req     out  1       ROM read request
//   rom_ack     in   1       ROM data valid this cycle (wait states allowed)
//   rom_data    in   DATA_W  ROM read data, sampled when rom_req & rom_ack
//   load_pc     in   1       from decode: jump, PC <= {oprnd,arg} (EXEC only)
//   we_flags    in   1       from decode: capture alu_c/alu_z (EXEC only)
//   alu_c       in   1       ALU carry
//   alu_z       in   1       ALU zero
//   instr       out  NIB_W   latched opcode nibble
//   oprnd       out  NIB_W   latched operand nibble
//   mem_addr    out  ADDR_W  data-RAM address {oprnd, arg}
//   decode_addr out  7       {instr, c_flag, z_flag, phase} to decode ROM
//   phase       out  1       0 during fetch states, 1 during EXEC
// BEHAVIOUR
//   Reset (reset=0, immediate, any state): pc=0, state=F_INS, ir=0, arg=0, c_flag=z_flag=0.
//     Outputs then: rom_addr=0, rom_req=enable, instr=oprnd=0, mem_addr=0, phase=0,
//     decode_addr=7'b0. Reset mid-fetch abandons the read; no partial latch.
//   FSM states: F_INS -> F_ARG -> EXEC -> F_INS. Registered state, one-hot or binary.
//   F_INS: rom_req=enable, rom_addr=pc. On edge with enable & rom_ack: ir<=rom_data,
//     pc<=pc+1, go F_ARG. Else hold (rom_addr, rom_req stable through wait states).
//   F_ARG: same handshake; on ack: arg<=rom_data, pc<=pc+1, go EXEC.
//   EXEC: rom_req=0, phase=1, exactly one cycle when enable=1. At its edge:
//     load_pc=1 -> pc<={oprnd,arg} (overrides increment); else pc unchanged.
//     we_flags=1 -> c_flag<=alu_c, z_flag<=alu_z; else flags hold. Then go F_INS.
//   load_pc/we_flags ignored in F_INS/F_ARG. Both may be 1 together in EXEC; both apply.
//   rom_ack ignored when rom_req=0. enable=0 overrides rom_ack; state, pc, ir, arg, flags hold.
//   Minimum instruction time 3 cycles (ack in same cycle as req); each wait cycle adds one.
//   pc arithmetic modulo 2^ADDR_W: 12'hFFF + 1 = 12'h000; no overflow flag.
//   decode_addr combinational from registers: {ir[7:4], c_flag, z_flag, phase};
//     in fetch states it carries the previous instr (decode maps phase 0 regardless).
//   instr=ir[7:4], oprnd=ir[3:0], mem_addr={ir[3:0], arg}; stable throughout EXEC.
// TESTING
//   T1 reset: drop reset mid-F_ARG -> same instant pc=0, phase=0, decode_addr=0, rom_req=1.
//   T2 zero-wait: ROM[0]=8'h3A, ROM[1]=8'h5C, ack tied 1 -> EXEC in cycle 3, instr=3,
//      oprnd=A, mem_addr=12'hA5C, decode_addr=7'b0011_00_1, pc=2.
//   T3 wait states: ack low 4 cycles in F_INS -> rom_addr=0, rom_req=1 held, EXEC at cycle 7.
//   T4 jump: ROM[2]=8'hD1, ROM[3]=8'h23, load_pc=1 in EXEC -> next rom_addr=12'h123.
//   T5 flags/wrap: pc preset via jump to 12'hFFE, we_flags=1 with alu_c=1, alu_z=0 ->
//      after EXEC pc=12'h000, decode_addr[2:1]=2'b10 next instruction.
//   T6 freeze: enable=0 for 3 cycles in EXEC with ack=1 -> no state/pc/flag change,
//      rom_req=0; resumes to F_INS on first enabled edge.

Source files
------------

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_sequencer : PC, ROM fetch handshake, IR/ARG and C/Z flag holder    |
// |                   feeding the decode ROM.                  Rev 1.0        |
// +--------------------------------------------------------------------------+
module fetch_sequencer #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int NIB_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_req,
  input  logic              rom_ack,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              load_pc,
  input  logic              we_flags,
  input  logic              alu_c,
  input  logic              alu_z,
  output logic [NIB_W-1:0]  instr,
  output logic [NIB_W-1:0]  oprnd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [6:0]        decode_addr,
  output logic              phase
);

  typedef enum logic [1:0] {
    F_INS = 2'd0,
    F_ARG = 2'd1,
    EXEC  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] C_PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic [DATA_W-1:0]   r_ir;
  logic [DATA_W-1:0]   w_ir_nxt;
  logic [DATA_W-1:0]   r_arg;
  logic [DATA_W-1:0]   w_arg_nxt;
  logic                r_c_flag;
  logic                w_c_nxt;
  logic                r_z_flag;
  logic                w_z_nxt;
  logic                w_fetching;
  logic                w_fire;

  // State only advances while enabled, so freezing needs no per-register gating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= F_INS;
      r_pc     <= '0;
      r_ir     <= '0;
      r_arg    <= '0;
      r_c_flag <= 1'b0;
      r_z_flag <= 1'b0;
    end else if (enable) begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_ir     <= w_ir_nxt;
      r_arg    <= w_arg_nxt;
      r_c_flag <= w_c_nxt;
      r_z_flag <= w_z_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_arg_nxt   = r_arg;
    w_c_nxt     = r_c_flag;
    w_z_nxt     = r_z_flag;
    case (r_state)
      F_INS: begin
        if (w_fire) begin
          w_ir_nxt    = rom_data;
          w_pc_nxt    = r_pc + C_PC_ONE;
          w_state_nxt = F_ARG;
        end
      end
      F_ARG: begin
        if (w_fire) begin
          w_arg_nxt   = rom_data;
          w_pc_nxt    = r_pc + C_PC_ONE;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (load_pc) begin
          w_pc_nxt = {r_ir[NIB_W-1:0], r_arg};
        end
        if (we_flags) begin
          w_c_nxt = alu_c;
          w_z_nxt = alu_z;
        end
        w_state_nxt = F_INS;
      end
      default: begin
        w_state_nxt = F_INS;
      end
    endcase
  end

  assign w_fetching  = (r_state == F_INS) || (r_state == F_ARG);
  assign rom_req     = enable && w_fetching;
  assign w_fire      = rom_req && rom_ack;
  assign rom_addr    = r_pc;
  assign phase       = (r_state == EXEC);
  assign instr       = r_ir[DATA_W-1 -: NIB_W];
  assign oprnd       = r_ir[NIB_W-1:0];
  assign mem_addr    = {r_ir[NIB_W-1:0], r_arg};
  // During fetch this still carries the previous opcode; decode ignores it at phase 0.
  assign decode_addr = {r_ir[DATA_W-1 -: NIB_W], r_c_flag, r_z_flag, phase};

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_sequencer : directed + randomized check against a cycle model.  |
// |                                                           Rev 1.0        |
// +--------------------------------------------------------------------------+
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [11:0] rom_addr;
  logic        rom_req;
  logic        rom_ack;
  logic [7:0]  rom_data;
  logic        load_pc;
  logic        we_flags;
  logic        alu_c;
  logic        alu_z;
  logic [3:0]  instr;
  logic [3:0]  oprnd;
  logic [11:0] mem_addr;
  logic [6:0]  decode_addr;
  logic        phase;

  logic [7:0]  rom [4096];

  int n_asserts = 0;
  int n_fail    = 0;

  // Model: program counter, opcode byte, argument byte, flags, step 0/1/2.
  int m_pc, m_ir, m_arg, m_c, m_z, m_ph, m_en;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  fetch_sequencer #(.ADDR_W(12), .DATA_W(8), .NIB_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .rom_addr    (rom_addr),
    .rom_req     (rom_req),
    .rom_ack     (rom_ack),
    .rom_data    (rom_data),
    .load_pc     (load_pc),
    .we_flags    (we_flags),
    .alu_c       (alu_c),
    .alu_z       (alu_z),
    .instr       (instr),
    .oprnd       (oprnd),
    .mem_addr    (mem_addr),
    .decode_addr (decode_addr),
    .phase       (phase)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_arg = 0; m_c = 0; m_z = 0; m_ph = 0;
  endtask

  task automatic check_model();
    chk("rom_addr",    {20'd0, rom_addr},   m_pc);
    chk("rom_req",     {31'd0, rom_req},    (m_en != 0 && m_ph != 2) ? 1 : 0);
    chk("phase",       {31'd0, phase},      (m_ph == 2) ? 1 : 0);
    chk("instr",       {28'd0, instr},      m_ir / 16);
    chk("oprnd",       {28'd0, oprnd},      m_ir % 16);
    chk("mem_addr",    {20'd0, mem_addr},   (m_ir % 16) * 256 + m_arg);
    chk("decode_addr", {25'd0, decode_addr},
        (m_ir / 16) * 8 + m_c * 4 + m_z * 2 + ((m_ph == 2) ? 1 : 0));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic step(input logic en, input logic ack, input logic lp,
                      input logic wf, input logic ac, input logic az);
    enable = en; rom_ack = ack; load_pc = lp; we_flags = wf; alu_c = ac; alu_z = az;
    m_en = en;
    @(posedge clk);
    if (en) begin
      case (m_ph)
        0: if (ack) begin m_ir  = rom[m_pc]; m_pc = (m_pc + 1) % 4096; m_ph = 1; end
        1: if (ack) begin m_arg = rom[m_pc]; m_pc = (m_pc + 1) % 4096; m_ph = 2; end
        default: begin
          if (lp) m_pc = (m_ir % 16) * 256 + m_arg;
          if (wf) begin m_c = ac; m_z = az; end
          m_ph = 0;
        end
      endcase
    end
    #2;
    check_model();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_rom_addr", {20'd0, rom_addr}, 0);
    chk("rst_phase",    {31'd0, phase}, 0);
    chk("rst_decode",   {25'd0, decode_addr}, 0);
    chk("rst_rom_req",  {31'd0, rom_req}, {31'd0, enable});
    check_model();
    #1;
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    rom[12'h000] = 8'h3A; rom[12'h001] = 8'h5C;
    rom[12'h002] = 8'hD1; rom[12'h003] = 8'h23;
    rom[12'h123] = 8'h7F; rom[12'h124] = 8'hFE;
    rom[12'hFFE] = 8'h40; rom[12'hFFF] = 8'h11;

    reset = 1'b0; enable = 1'b1; rom_ack = 1'b0; load_pc = 1'b0;
    we_flags = 1'b0; alu_c = 1'b0; alu_z = 1'b0;
    model_reset(); m_en = 1;
    @(posedge clk); @(posedge clk); #2;
    check_model();
    reset = 1'b1;

    // Reset while waiting in F_ARG.
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 1, 1, 1);
    chk("t1_in_farg", {20'd0, rom_addr}, 1);
    async_reset();

    // Zero-wait instruction.
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("t2_phase",    {31'd0, phase}, 1);
    chk("t2_instr",    {28'd0, instr}, 4'h3);
    chk("t2_oprnd",    {28'd0, oprnd}, 4'hA);
    chk("t2_mem_addr", {20'd0, mem_addr}, 12'hA5C);
    chk("t2_decode",   {25'd0, decode_addr}, 7'b0011001);
    chk("t2_pc",       {20'd0, rom_addr}, 12'h002);
    async_reset();

    // Four wait states in F_INS.
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, 1, 1, 1);
      chk("t3_req_held",  {31'd0, rom_req}, 1);
      chk("t3_addr_held", {20'd0, rom_addr}, 0);
    end
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("t3_exec_c7", {31'd0, phase}, 1);
    step(1, 1, 0, 0, 0, 0);

    // Jump to 0x123.
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    chk("t4_jump", {20'd0, rom_addr}, 12'h123);

    // Jump to 0xFFE, then wrap and write flags.
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    chk("t5_preset", {20'd0, rom_addr}, 12'hFFE);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 1, 0);
    chk("t5_wrap", {20'd0, rom_addr}, 12'h000);
    step(1, 0, 0, 0, 0, 0);
    chk("t5_flags", {30'd0, decode_addr[2:1]}, 2'b10);

    // Freeze in EXEC.
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 1, 0, 1);
      chk("t6_frozen_phase", {31'd0, phase}, 1);
      chk("t6_frozen_req",   {31'd0, rom_req}, 0);
      chk("t6_frozen_pc",    {20'd0, rom_addr}, 12'h002);
    end
    step(1, 1, 0, 0, 0, 0);
    chk("t6_resume", {31'd0, phase}, 0);

    // Randomized traffic with occasional mid-cycle resets.
    for (int i = 0; i < 3000; i++) begin
      if (i % 701 == 700) async_reset();
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 2) != 0),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
